// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions for the hazard detection slice.
//   - forwarding-select encodings driven onto fwd_a / fwd_b
//   - bit positions of the decoder's operand-usage flags (id_use)
//   - default register-index width and the shadow-entry control fields
package hazard_detect_unit_pkg;

    // Forwarding select encodings for EX operand muxes
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // id_use bit positions
    localparam int USE_A = 1;
    localparam int USE_B = 0;

    // Default register index width (4 architectural registers)
    localparam int REG_W = 2;

    typedef logic [1:0] fwd_sel_t;

    // Control half of a shadow entry; valid and rd are carried beside it
    // so the register index width can follow the module parameter.
    typedef struct packed {
        logic wr_en;
        logic is_load;
    } shd_ctl_t;

endpackage

// File: rtl/hazard_detect_unit_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one EX source operand.
// Compares the operand's register index against the in-flight writers in
// EX and MEM and returns the mux select. The youngest producer (EX) wins.
// Ports:
//   rd_used  in  operand is actually read by the instruction
//   src      in  source register index
//   ex_live  in  EX shadow entry is a valid register writer
//   ex_rd    in  EX shadow entry destination
//   mem_live in  MEM shadow entry is a valid register writer
//   mem_rd   in  MEM shadow entry destination
//   sel      out forwarding select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
module hazard_fwd_sel
    import hazard_detect_unit_pkg::*;
#(
    parameter int NREG_W = REG_W
) (
    input  logic              rd_used,
    input  logic [NREG_W-1:0] src,
    input  logic              ex_live,
    input  logic [NREG_W-1:0] ex_rd,
    input  logic              mem_live,
    input  logic [NREG_W-1:0] mem_rd,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (rd_used && mem_live && (src == mem_rd)) sel = FWD_MEMWB;
        // EX check last so the younger producer overrides MEM
        if (rd_used && ex_live && (src == ex_rd))   sel = FWD_EXMEM;
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use stall, EX bubble insertion and registered
// EX forwarding selects, driven from a shadow of the EX/MEM pipeline.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   id_valid         decode stage holds a real instruction
//   id_use[1:0]      operand usage (bit1 reads A, bit0 reads B)
//   id_ra, id_rb     source registers
//   id_wr_en, id_rd  destination write enable / register
//   id_is_load       decode instruction is a load
//   flush            kill the ID instruction (taken branch in EX)
//   mem_wait         freeze the whole pipeline
//   stall            hold PC and IF/ID (combinational)
//   bubble_ex        load NOP into ID/EX (combinational)
//   fwd_a, fwd_b     registered EX operand selects
//   stall_cnt        saturating count of load-use stall cycles
// A writer leaving MEM needs no tracking: the register file is write-first,
// so a WB-stage producer is already visible to a reader in decode.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int NREG_W = REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [1:0]        id_use,
    input  logic [NREG_W-1:0] id_ra,
    input  logic [NREG_W-1:0] id_rb,
    input  logic              id_wr_en,
    input  logic [NREG_W-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_wait,
    output logic              stall,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Shadow pipe: _p0 = EX entry, _p1 = MEM entry
    logic              vld_p0;
    shd_ctl_t          ctl_p0;
    logic [NREG_W-1:0] rd_p0;
    logic              vld_p1;
    logic              wr_p1;
    logic [NREG_W-1:0] rd_p1;

    logic     ex_live;
    logic     mem_live;
    logic     lu;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    assign ex_live  = vld_p0 & ctl_p0.wr_en;
    assign mem_live = vld_p1 & wr_p1;

    assign lu = id_valid & ex_live & ctl_p0.is_load &
                ((id_use[USE_A] & (id_ra == rd_p0)) |
                 (id_use[USE_B] & (id_rb == rd_p0)));

    // Priority: freeze > flush > load-use
    always_comb begin
        stall     = 1'b0;
        bubble_ex = 1'b0;
        if (mem_wait) begin
            stall = 1'b1;
        end else if (flush) begin
            bubble_ex = 1'b1;
        end else if (lu) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    hazard_fwd_sel #(.NREG_W(NREG_W)) u_sel_a (
        .rd_used  (id_use[USE_A]),
        .src      (id_ra),
        .ex_live  (ex_live),
        .ex_rd    (rd_p0),
        .mem_live (mem_live),
        .mem_rd   (rd_p1),
        .sel      (sel_a)
    );

    hazard_fwd_sel #(.NREG_W(NREG_W)) u_sel_b (
        .rd_used  (id_use[USE_B]),
        .src      (id_rb),
        .ex_live  (ex_live),
        .ex_rd    (rd_p0),
        .mem_live (mem_live),
        .mem_rd   (rd_p1),
        .sel      (sel_b)
    );

    // ID -> EX -> MEM: control state, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else if (!mem_wait) begin
            vld_p1 <= vld_p0;
            vld_p0 <= id_valid & ~bubble_ex;
            fwd_a  <= bubble_ex ? FWD_RF : sel_a;
            fwd_b  <= bubble_ex ? FWD_RF : sel_b;
            if (lu && !flush) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // ID -> EX -> MEM: entry payload, qualified by vld_pN
    always_ff @(posedge clk) begin
        if (!mem_wait) begin
            ctl_p0 <= '{wr_en: id_wr_en, is_load: id_is_load};
            rd_p0  <= id_rd;
            wr_p1  <= ctl_p0.wr_en;
            rd_p1  <= rd_p0;
        end
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;
    import hazard_detect_unit_pkg::*;

    localparam int NREG_W = 2;
    localparam int CNT_W  = 3;   // narrow so saturation is reachable

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [1:0]        id_use;
    logic [NREG_W-1:0] id_ra, id_rb, id_rd;
    logic              id_wr_en, id_is_load, flush, mem_wait;
    logic              stall, bubble_ex;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    hazard_detect_unit #(.NREG_W(NREG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_use(id_use),
        .id_ra(id_ra), .id_rb(id_rb), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .mem_wait(mem_wait),
        .stall(stall), .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic              m_v0 = 0, m_v1 = 0, m_w0 = 0, m_w1 = 0, m_l0 = 0;
    logic [NREG_W-1:0] m_r0 = '0, m_r1 = '0;
    logic [1:0]        m_fa = '0, m_fb = '0;
    logic [CNT_W-1:0]  m_cnt = '0;
    bit                m_known = 0;
    logic              last_stall, last_bubble;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rstn, input logic valid, input logic [1:0] use_f,
                       input logic [NREG_W-1:0] ra, input logic [NREG_W-1:0] rb,
                       input logic wr, input logic [NREG_W-1:0] rd, input logic ld,
                       input logic fl, input logic mw);
        logic exl, meml, lu, es, eb;
        logic [1:0] nfa, nfb;
        exp_t e;
        @(negedge clk);
        rst_n = rstn; id_valid = valid; id_use = use_f; id_ra = ra; id_rb = rb;
        id_wr_en = wr; id_rd = rd; id_is_load = ld; flush = fl; mem_wait = mw;

        exl  = m_v0 && m_w0;
        meml = m_v1 && m_w1;
        lu   = valid && exl && m_l0 &&
               ((use_f[1] && ra == m_r0) || (use_f[0] && rb == m_r0));
        if (mw)      begin es = 1'b1; eb = 1'b0; end
        else if (fl) begin es = 1'b0; eb = 1'b1; end
        else if (lu) begin es = 1'b1; eb = 1'b1; end
        else         begin es = 1'b0; eb = 1'b0; end

        #2;
        last_stall  = stall;
        last_bubble = bubble_ex;
        if (m_known) begin
            check("stall", 32'(stall), 32'(es));
            check("bubble_ex", 32'(bubble_ex), 32'(eb));
        end

        if (!rstn) begin
            m_v0 = 0; m_v1 = 0; m_fa = FWD_RF; m_fb = FWD_RF; m_cnt = '0;
            m_known = 1;
        end else if (!mw) begin
            if (eb)                                  nfa = FWD_RF;
            else if (use_f[1] && exl  && ra == m_r0) nfa = FWD_EXMEM;
            else if (use_f[1] && meml && ra == m_r1) nfa = FWD_MEMWB;
            else                                     nfa = FWD_RF;
            if (eb)                                  nfb = FWD_RF;
            else if (use_f[0] && exl  && rb == m_r0) nfb = FWD_EXMEM;
            else if (use_f[0] && meml && rb == m_r1) nfb = FWD_MEMWB;
            else                                     nfb = FWD_RF;
            if (lu && !fl && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            m_v1 = m_v0; m_w1 = m_w0; m_r1 = m_r0;
            m_v0 = valid && !eb; m_w0 = wr; m_r0 = rd; m_l0 = ld;
            m_fa = nfa; m_fb = nfb;
        end
        e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("fwd_a", 32'(fwd_a), 32'(e.fa));
        check("fwd_b", 32'(fwd_b), 32'(e.fb));
        check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    endtask

    task automatic alu(input logic [1:0] use_f, input logic [NREG_W-1:0] ra,
                       input logic [NREG_W-1:0] rb, input logic [NREG_W-1:0] rd);
        cyc(1'b1, 1'b1, use_f, ra, rb, 1'b1, rd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [NREG_W-1:0] rd);
        cyc(1'b1, 1'b1, 2'b00, '0, '0, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with a valid, flushed instruction presented
        cyc(1'b0, 1'b1, 2'b11, 2'd1, 2'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 2'd1, 2'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_stall", 32'(last_stall), 32'd0);

        // ALU back-to-back forwarding
        alu(2'b00, 2'd0, 2'd0, 2'd2);               // I1 writes R2
        check("first_no_stall", 32'(last_stall), 32'd0);
        alu(2'b10, 2'd2, 2'd0, 2'd3);               // I2 reads A=R2
        check("alu_fwd_a_exmem", 32'(fwd_a), 32'(FWD_EXMEM));
        check("alu_fwd_b_rf", 32'(fwd_b), 32'(FWD_RF));
        alu(2'b01, 2'd1, 2'd2, 2'd0);               // I3 reads B=R2
        check("alu_fwd_b_memwb", 32'(fwd_b), 32'(FWD_MEMWB));
        check("alu_fwd_a_unused", 32'(fwd_a), 32'(FWD_RF));

        // Load-use: one stall cycle, then MEM/WB forward
        ld(2'd1);
        alu(2'b10, 2'd1, 2'd0, 2'd0);
        check("lu_stall", 32'(last_stall), 32'd1);
        check("lu_bubble", 32'(last_bubble), 32'd1);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        check("lu_bubble_fwd", 32'(fwd_a), 32'(FWD_RF));
        alu(2'b10, 2'd1, 2'd0, 2'd0);
        check("lu_after_stall", 32'(last_stall), 32'd0);
        check("lu_fwd_memwb", 32'(fwd_a), 32'(FWD_MEMWB));

        // Unused operand does not trigger load-use
        ld(2'd3);
        alu(2'b00, 2'd3, 2'd3, 2'd2);
        check("unused_stall", 32'(last_stall), 32'd0);
        check("unused_fwd_a", 32'(fwd_a), 32'(FWD_RF));

        // Flush overrides load-use; flushed instruction never reaches EX
        ld(2'd1);
        cyc(1'b1, 1'b1, 2'b10, 2'd1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        check("flush_stall", 32'(last_stall), 32'd0);
        check("flush_bubble", 32'(last_bubble), 32'd1);
        check("flush_cnt", 32'(stall_cnt), 32'd1);
        alu(2'b10, 2'd1, 2'd0, 2'd2);
        check("flush_ex_invalid", 32'(fwd_a), 32'(FWD_MEMWB));

        // mem_wait freeze during a pending load-use
        cyc(1'b1, 1'b1, 2'b10, 2'd2, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        check("ld_fwd_a", 32'(fwd_a), 32'(FWD_EXMEM));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 2'b10, 2'd2, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
            check("mw_stall", 32'(last_stall), 32'd1);
            check("mw_bubble", 32'(last_bubble), 32'd0);
            check("mw_fwd_hold", 32'(fwd_a), 32'(FWD_EXMEM));
            check("mw_cnt_hold", 32'(stall_cnt), 32'd1);
        end
        alu(2'b10, 2'd2, 2'd0, 2'd3);
        check("mw_release_lu", 32'(last_bubble), 32'd1);
        check("mw_release_cnt", 32'(stall_cnt), 32'd2);
        alu(2'b10, 2'd2, 2'd0, 2'd3);
        check("mw_once", 32'(last_stall), 32'd0);
        check("mw_fwd_memwb", 32'(fwd_a), 32'(FWD_MEMWB));

        // Reset mid-operation drops in-flight writers
        alu(2'b00, 2'd0, 2'd0, 2'd1);
        cyc(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        alu(2'b11, 2'd1, 2'd1, 2'd0);
        check("midrst_fwd_a", 32'(fwd_a), 32'(FWD_RF));
        check("midrst_fwd_b", 32'(fwd_b), 32'(FWD_RF));
        check("midrst_cnt", 32'(stall_cnt), 32'd0);

        // Counter saturation
        for (int i = 0; i < 10; i++) begin
            logic [NREG_W-1:0] r;
            r = NREG_W'($urandom_range(0, 3));
            ld(r);
            alu(2'b01, 2'd0, r, r + 2'd1);
            check("sat_cnt", 32'(stall_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
            alu(2'b01, 2'd0, r, r + 2'd1);
        end
        ld(2'd0);
        cyc(1'b1, 1'b1, 2'b10, 2'd0, 2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        check("sat_mw_hold", 32'(stall_cnt), 32'd7);
        alu(2'b10, 2'd0, 2'd1, 2'd2);
        check("sat_stays", 32'(stall_cnt), 32'd7);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 5) != 0),
                2'($urandom_range(0, 3)), NREG_W'($urandom_range(0, 3)),
                NREG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                NREG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
